// File: rtl/q_learning_pkg.sv
`default_nettype none
// ============================================================================
// Module      : q_learning_pkg
// Description : Shared widths, types and number-format helpers for the
//               Q-learning update pipeline. Q values and rewards travel on
//               ports as 14-bit sign-magnitude (bit13 sign, [12:9] integer,
//               [8:0] fraction). Internally they are 16-bit two's complement.
// Revision    : 1.0 - initial release
// ============================================================================
package q_learning_pkg;

  localparam int Q_W     = 14;
  localparam int INT_W   = 4;
  localparam int FRAC_W  = 9;
  localparam int STATE_W = 3;
  localparam int ACT_W   = 2;
  localparam int ARITH_W = 16;

  typedef logic signed [ARITH_W-1:0] q_tc_t;

  // Largest representable magnitude, 2^INT_W - 2^-FRAC_W in raw units.
  localparam q_tc_t C_MAG_LIM = q_tc_t'((1 << (INT_W + FRAC_W)) - 1);

  // Sign-magnitude to two's complement. Negative zero maps to 0.
  function automatic q_tc_t sm2tc(input logic [Q_W-1:0] sm);
    q_tc_t mag;
    mag = {{(ARITH_W-Q_W+1){1'b0}}, sm[Q_W-2:0]};
    return sm[Q_W-1] ? -mag : mag;
  endfunction

  // Two's complement to sign-magnitude with magnitude saturation.
  function automatic logic [Q_W-1:0] tc2sm_sat(input q_tc_t v);
    q_tc_t mag;
    logic  neg;
    neg = v[ARITH_W-1];
    mag = neg ? -v : v;
    if (mag > C_MAG_LIM) begin
      mag = C_MAG_LIM;
    end
    return {neg, (Q_W-1)'(mag)};
  endfunction

endpackage : q_learning_pkg
`default_nettype wire

// File: rtl/q_row_argmax.sv
`default_nettype none
// ============================================================================
// Module      : q_row_argmax
// Description : Combinational signed max / argmax over one row of the
//               Q-table. Ties resolve to the lowest action index.
// Ports       : row_i  - Q values of one state, two's complement
//               max_o  - largest value in the row
//               idx_o  - action index of that value
// Revision    : 1.0 - initial release
// ============================================================================
module q_row_argmax
  import q_learning_pkg::*;
#(
  parameter int N_ACTIONS = 4
) (
  input  q_tc_t            row_i [N_ACTIONS],
  output q_tc_t            max_o,
  output logic [ACT_W-1:0] idx_o
);

  always_comb begin
    max_o = row_i[0];
    idx_o = '0;
    // Strict greater-than keeps the earliest index on a tie.
    for (int a = 1; a < N_ACTIONS; a++) begin
      if (row_i[a] > max_o) begin
        max_o = row_i[a];
        idx_o = ACT_W'(a);
      end
    end
  end

endmodule : q_row_argmax
`default_nettype wire

// File: rtl/q_update_pipe.sv
`default_nettype none
// ============================================================================
// Module      : q_update_pipe
// Description : Three-stage Q-learning update.
//               Q(s,a) <= Q(s,a) + alpha*(r + gamma*maxQ(s') - Q(s,a))
//               alpha = 2^-ALPHA_SHIFT, gamma = 1 - 2^-GAMMA_SHIFT.
//               Stage 1 reads q_old and the row max of s' (accept edge),
//               stage 2 forms the TD delta, stage 3 applies, saturates and
//               writes the table (upd_* valid three cycles after accept).
// Ports       : CLK, RST (async, active low)
//               in_valid/in_ready, S_prev, A_prev, S_current, rewardIn
//               upd_valid, upd_state, upd_action, upd_q - table write report
//               best_action - greedy action for the last accepted S_current
// Revision    : 1.0 - initial release
// ============================================================================
module q_update_pipe
  import q_learning_pkg::*;
#(
  parameter int N_STATES    = 8,
  parameter int N_ACTIONS   = 4,
  parameter int ALPHA_SHIFT = 1,
  parameter int GAMMA_SHIFT = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] S_prev,
  input  logic [ACT_W-1:0]   A_prev,
  input  logic [STATE_W-1:0] S_current,
  input  logic [Q_W-1:0]     rewardIn,
  output logic               upd_valid,
  output logic [STATE_W-1:0] upd_state,
  output logic [ACT_W-1:0]   upd_action,
  output logic [Q_W-1:0]     upd_q,
  output logic [ACT_W-1:0]   best_action
);

  q_tc_t tab_q [N_STATES][N_ACTIONS];

  // Stage 1: operands captured on the accept edge
  logic               s1_vld_q;
  logic [STATE_W-1:0] s1_state_q;
  logic [ACT_W-1:0]   s1_act_q;
  q_tc_t              s1_r_q;
  q_tc_t              s1_qold_q;
  q_tc_t              s1_max_q;

  // Stage 2: TD delta
  logic               s2_vld_q;
  logic [STATE_W-1:0] s2_state_q;
  logic [ACT_W-1:0]   s2_act_q;
  q_tc_t              s2_qold_q;
  q_tc_t              s2_delta_q;

  // Stage 3: operands of the write happening on the next edge
  logic               s3_vld_q;
  logic [STATE_W-1:0] s3_state_q;
  logic [ACT_W-1:0]   s3_act_q;
  q_tc_t              s3_qold_q;
  q_tc_t              s3_delta_q;

  logic               upd_valid_q;
  logic [STATE_W-1:0] upd_state_q;
  logic [ACT_W-1:0]   upd_action_q;
  logic [Q_W-1:0]     upd_q_q;
  logic [ACT_W-1:0]   best_action_q;

  q_tc_t              w_r;
  q_tc_t              w_row [N_ACTIONS];
  q_tc_t              w_t;
  q_tc_t              w_q_sum;
  logic               w_haz_s1;
  logic               w_haz_s2;
  logic               w_accept;

  q_tc_t              q_old_d;
  q_tc_t              row_max_d;
  logic [ACT_W-1:0]   row_idx_d;
  q_tc_t              delta_d;
  logic [Q_W-1:0]     q_new_sm_d;
  q_tc_t              q_new_d;

  assign w_r = sm2tc(rewardIn);

  // Stage 3 arithmetic. The value is round-tripped through the saturating
  // sign-magnitude conversion so the table holds exactly what upd_q reports.
  assign w_q_sum    = s3_qold_q + (s3_delta_q >>> ALPHA_SHIFT);
  assign q_new_sm_d = tc2sm_sat(w_q_sum);
  assign q_new_d    = sm2tc(q_new_sm_d);

  // Stage 1 reads with write-first bypass from stage 3, so a transition that
  // depends on the entry being written this edge sees the new value.
  always_comb begin
    q_old_d = tab_q[S_prev][A_prev];
    if (s3_vld_q && (s3_state_q == S_prev) && (s3_act_q == A_prev)) begin
      q_old_d = q_new_d;
    end
    for (int a = 0; a < N_ACTIONS; a++) begin
      w_row[a] = tab_q[S_current][a];
      if (s3_vld_q && (s3_state_q == S_current) && (s3_act_q == ACT_W'(a))) begin
        w_row[a] = q_new_d;
      end
    end
  end

  q_row_argmax #(
    .N_ACTIONS (N_ACTIONS)
  ) u_row_argmax (
    .row_i (w_row),
    .max_o (row_max_d),
    .idx_o (row_idx_d)
  );

  // Stage 2 arithmetic: gamma*maxQ as maxQ - (maxQ >>> GAMMA_SHIFT).
  assign w_t     = s1_r_q + s1_max_q - (s1_max_q >>> GAMMA_SHIFT);
  assign delta_d = w_t - s1_qold_q;

  // Entries in stages 1-2 are not yet visible through the bypass, so any
  // read that touches them must wait until they reach stage 3.
  assign w_haz_s1 = s1_vld_q &&
                    (((S_prev == s1_state_q) && (A_prev == s1_act_q)) ||
                     (S_current == s1_state_q));
  assign w_haz_s2 = s2_vld_q &&
                    (((S_prev == s2_state_q) && (A_prev == s2_act_q)) ||
                     (S_current == s2_state_q));
  assign in_ready = !(w_haz_s1 || w_haz_s2);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int s = 0; s < N_STATES; s++) begin
        for (int a = 0; a < N_ACTIONS; a++) begin
          tab_q[s][a] <= '0;
        end
      end
      s1_vld_q      <= 1'b0;
      s1_state_q    <= '0;
      s1_act_q      <= '0;
      s1_r_q        <= '0;
      s1_qold_q     <= '0;
      s1_max_q      <= '0;
      s2_vld_q      <= 1'b0;
      s2_state_q    <= '0;
      s2_act_q      <= '0;
      s2_qold_q     <= '0;
      s2_delta_q    <= '0;
      s3_vld_q      <= 1'b0;
      s3_state_q    <= '0;
      s3_act_q      <= '0;
      s3_qold_q     <= '0;
      s3_delta_q    <= '0;
      upd_valid_q   <= 1'b0;
      upd_state_q   <= '0;
      upd_action_q  <= '0;
      upd_q_q       <= '0;
      best_action_q <= '0;
    end else begin
      s1_vld_q <= w_accept;
      if (w_accept) begin
        s1_state_q    <= S_prev;
        s1_act_q      <= A_prev;
        s1_r_q        <= w_r;
        s1_qold_q     <= q_old_d;
        s1_max_q      <= row_max_d;
        best_action_q <= row_idx_d;
      end

      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_state_q <= s1_state_q;
        s2_act_q   <= s1_act_q;
        s2_qold_q  <= s1_qold_q;
        s2_delta_q <= delta_d;
      end

      s3_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        s3_state_q <= s2_state_q;
        s3_act_q   <= s2_act_q;
        s3_qold_q  <= s2_qold_q;
        s3_delta_q <= s2_delta_q;
      end

      upd_valid_q <= s3_vld_q;
      if (s3_vld_q) begin
        tab_q[s3_state_q][s3_act_q] <= q_new_d;
        upd_state_q                 <= s3_state_q;
        upd_action_q                <= s3_act_q;
        upd_q_q                     <= q_new_sm_d;
      end
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_state   = upd_state_q;
  assign upd_action  = upd_action_q;
  assign upd_q       = upd_q_q;
  assign best_action = best_action_q;

endmodule : q_update_pipe
`default_nettype wire

// File: tb/tb_q_update_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_q_update_pipe
// Description : Self-checking bench for q_update_pipe. A behavioural Q-table
//               model predicts every table write; predictions are queued at
//               acceptance and retired when upd_valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_q_update_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  S_prev;
  logic [1:0]  A_prev;
  logic [2:0]  S_current;
  logic [13:0] rewardIn;
  logic        upd_valid;
  logic [2:0]  upd_state;
  logic [1:0]  upd_action;
  logic [13:0] upd_q;
  logic [1:0]  best_action;

  q_update_pipe #(
    .N_STATES    (8),
    .N_ACTIONS   (4),
    .ALPHA_SHIFT (1),
    .GAMMA_SHIFT (1)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .S_prev      (S_prev),
    .A_prev      (A_prev),
    .S_current   (S_current),
    .rewardIn    (rewardIn),
    .upd_valid   (upd_valid),
    .upd_state   (upd_state),
    .upd_action  (upd_action),
    .upd_q       (upd_q),
    .best_action (best_action)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  s;
    logic [1:0]  a;
    logic [13:0] q;
  } exp_t;

  exp_t        sb[$];
  longint      upd_t[$];
  int          model_q [8][4];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [1:0]  exp_best;
  logic [13:0] last_upd_q;
  longint      t_acc;

  // ---------------- reference model ----------------
  function automatic int sm_to_int(input logic [13:0] v);
    int mag;
    mag = int'(v[12:0]);
    return v[13] ? -mag : mag;
  endfunction

  function automatic int floor_half(input int x);
    return (x >= 0) ? (x / 2) : -((-x + 1) / 2);
  endfunction

  function automatic int clamp(input int x);
    if (x > 8191)  return 8191;
    if (x < -8191) return -8191;
    return x;
  endfunction

  function automatic logic [13:0] int_to_sm(input int x);
    logic [12:0] m;
    m = (x < 0) ? 13'(-x) : 13'(x);
    return {(x < 0), m};
  endfunction

  task automatic model_accept(input logic [2:0] sp, input logic [1:0] ap,
                              input logic [2:0] sc, input logic [13:0] r);
    int q, m, t, d, qn, best;
    q    = model_q[sp][ap];
    m    = model_q[sc][0];
    best = 0;
    for (int a = 1; a < 4; a++) begin
      if (model_q[sc][a] > m) begin
        m    = model_q[sc][a];
        best = a;
      end
    end
    t  = sm_to_int(r) + m - floor_half(m);
    d  = t - q;
    qn = clamp(q + floor_half(d));
    model_q[sp][ap] = qn;
    exp_best = 2'(best);
    sb.push_back('{s: sp, a: ap, q: int_to_sm(qn)});
  endtask

  task automatic model_clear();
    for (int s = 0; s < 8; s++)
      for (int a = 0; a < 4; a++)
        model_q[s][a] = 0;
  endtask

  // ---------------- scoreboard consumer ----------------
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (upd_valid === 1'b1) begin
      upd_t.push_back($time - 1);
      last_upd_q = upd_q;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL upd_unexpected: got s=%0d a=%0d q=%h, required no pulse",
                 upd_state, upd_action, upd_q);
      end else begin
        e = sb.pop_front();
        if ({upd_state, upd_action, upd_q} !== {e.s, e.a, e.q}) begin
          n_err++;
          $display("FAIL upd_entry: got s=%0d a=%0d q=%h, required s=%0d a=%0d q=%h",
                   upd_state, upd_action, upd_q, e.s, e.a, e.q);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [2:0] sp, input logic [1:0] ap,
                      input logic [2:0] sc, input logic [13:0] r,
                      output int stalls);
    bit ok;
    ok     = 1'b0;
    stalls = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      in_valid  = 1'b1;
      S_prev    = sp;
      A_prev    = ap;
      S_current = sc;
      rewardIn  = r;
      #1;
      ok = in_ready;
      @(posedge CLK);
      if (!ok) stalls++;
    end
    if (ok) begin
      t_acc = $time;
      model_accept(sp, ap, sc, r);
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_ready low for 20 cycles, required acceptance");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 20) begin
      @(posedge CLK);
      i++;
    end
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending updates, required 0", sb.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0; in_valid = 1'b0; S_prev = '0; A_prev = '0; S_current = '0; rewardIn = '0;
    model_clear();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({upd_valid, upd_state, upd_action, upd_q, best_action} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b s=%0d a=%0d q=%h best=%0d, required all 0",
               upd_valid, upd_state, upd_action, upd_q, best_action);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_first_update();
    int st;
    upd_t.delete();
    send(3'd0, 2'd1, 3'd1, 14'h0C00, st);
    #1;
    n_cmp++;
    if (best_action !== 2'd0) begin
      n_err++;
      $display("FAIL first_best: got %0d, required 0", best_action);
    end
    idle(1);
    drain();
    n_cmp++;
    if (last_upd_q !== 14'h0600) begin
      n_err++;
      $display("FAIL first_q: got %h, required 0600", last_upd_q);
    end
    n_cmp++;
    if (upd_t.size() != 1 || (upd_t[0] - t_acc) != 30) begin
      n_err++;
      $display("FAIL first_latency: got %0d pulses, required 1 pulse 30ns after accept", upd_t.size());
    end
  endtask

  task automatic test_row_argmax();
    int st, tot;
    tot = 0;
    send(3'd1, 2'd0, 3'd6, 14'h0400, st); tot += st;
    send(3'd1, 2'd2, 3'd6, 14'h0800, st); tot += st;
    send(3'd1, 2'd1, 3'd6, 14'h1000, st); tot += st;
    n_cmp++;
    if (tot != 0) begin
      n_err++;
      $display("FAIL row_fill_stalls: got %0d, required 0", tot);
    end
    // Row 1 is still in flight: stalls until its last write is in stage 3,
    // whose value (the row maximum) then arrives through the bypass.
    send(3'd2, 2'd0, 3'd1, 14'h2400, st);
    #1;
    n_cmp++;
    if (st != 2) begin
      n_err++;
      $display("FAIL row_hazard_stalls: got %0d, required 2", st);
    end
    n_cmp++;
    if (best_action !== 2'd1 || best_action !== exp_best) begin
      n_err++;
      $display("FAIL row_best: got %0d, required 1 (model %0d)", best_action, exp_best);
    end
    idle(1);
    drain();
  endtask

  task automatic test_back_to_back();
    int st;
    upd_t.delete();
    send(3'd3, 2'd2, 3'd5, 14'h0C00, st);
    send(3'd3, 2'd2, 3'd5, 14'h0C00, st);
    n_cmp++;
    if (st != 2) begin
      n_err++;
      $display("FAIL b2b_stalls: got %0d, required 2", st);
    end
    idle(1);
    drain();
    n_cmp++;
    if (last_upd_q !== 14'h0900) begin
      n_err++;
      $display("FAIL b2b_q: got %h, required 0900", last_upd_q);
    end
    n_cmp++;
    if (upd_t.size() != 2 || (upd_t[1] - upd_t[0]) != 30) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d pulses, required 2 pulses 30ns apart", upd_t.size());
    end
  endtask

  task automatic test_distinct();
    int st, tot;
    tot = 0;
    upd_t.delete();
    send(3'd5, 2'd0, 3'd6, 14'h0200, st); tot += st;
    send(3'd5, 2'd1, 3'd7, 14'h0400, st); tot += st;
    send(3'd6, 2'd2, 3'd0, 14'h0600, st); tot += st;
    send(3'd7, 2'd3, 3'd2, 14'h2200, st); tot += st;
    idle(1);
    drain();
    n_cmp++;
    if (tot != 0) begin
      n_err++;
      $display("FAIL distinct_stalls: got %0d, required 0", tot);
    end
    n_cmp++;
    if (upd_t.size() != 4 || (upd_t[3] - upd_t[0]) != 30) begin
      n_err++;
      $display("FAIL distinct_spacing: got %0d pulses, required 4 consecutive", upd_t.size());
    end
  endtask

  task automatic test_saturation();
    int st;
    for (int i = 0; i < 6; i++) send(3'd3, 2'd3, 3'd3, 14'h1FFF, st);
    idle(1);
    drain();
    n_cmp++;
    if (last_upd_q !== 14'h1FFF) begin
      n_err++;
      $display("FAIL sat_pos: got %h, required 1FFF", last_upd_q);
    end
    // Make every entry of row 4 negative so the row max itself is negative.
    for (int a = 0; a < 4; a++) send(3'd4, 2'(a), 3'd7, 14'h3FFF, st);
    for (int i = 0; i < 4; i++) send(3'd4, 2'd0, 3'd4, 14'h3FFF, st);
    #1;
    n_cmp++;
    if (best_action !== 2'd1 || best_action !== exp_best) begin
      n_err++;
      $display("FAIL sat_neg_best: got %0d, required 1 (model %0d)", best_action, exp_best);
    end
    idle(1);
    drain();
    n_cmp++;
    if (last_upd_q !== 14'h3FFF) begin
      n_err++;
      $display("FAIL sat_neg: got %h, required 3FFF", last_upd_q);
    end
  endtask

  task automatic test_reset_midflight();
    int st;
    upd_t.delete();
    send(3'd0, 2'd0, 3'd0, 14'h0400, st);
    send(3'd1, 2'd3, 3'd1, 14'h0400, st);
    #2;
    RST      = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({upd_valid, upd_state, upd_action, upd_q, best_action} !== 22'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: got v=%b s=%0d a=%0d q=%h best=%0d, required all 0",
               upd_valid, upd_state, upd_action, upd_q, best_action);
    end
    @(negedge CLK);
    RST = 1'b1;
    idle(5);
    n_cmp++;
    if (upd_t.size() != 0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_flush: got %0d pulses in_ready=%b, required 0 pulses in_ready=1",
               upd_t.size(), in_ready);
    end
    // Entries written before the reset must read back as zero.
    last_upd_q = 14'h3FFF;
    send(3'd3, 2'd3, 3'd1, 14'h0000, st);
    send(3'd4, 2'd0, 3'd4, 14'h0000, st);
    #1;
    n_cmp++;
    if (best_action !== 2'd0) begin
      n_err++;
      $display("FAIL midreset_best: got %0d, required 0", best_action);
    end
    idle(1);
    drain();
    n_cmp++;
    if (last_upd_q !== 14'h0000) begin
      n_err++;
      $display("FAIL midreset_table: got %h, required 0000", last_upd_q);
    end
  endtask

  initial begin
    test_reset();
    test_first_update();
    test_row_argmax();
    test_back_to_back();
    test_distinct();
    test_saturation();
    test_reset_midflight();
    idle(4);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL end_pending: got %0d, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200us");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_q_update_pipe
`default_nettype wire
